// File: rtl/ones_comp_muldiv_seq_pkg.sv
// ---------------------------------------------------------------------------
// ones_comp_pkg
// Shared definitions for the one's-complement multiply/divide unit:
//   DEFAULT_WIDTH : default word width (MSB is the one's-complement sign)
//   MAXW          : working width of the sign/magnitude helper functions
//   op_e          : operation select (OP_MUL / OP_DIV)
//   state_e       : sequencer states (IDLE, CHECK, RUN, FINISH)
//   to_mag()      : magnitude of a w-bit one's-complement word
//   apply_sign()  : w-bit one's-complement word from sign + magnitude,
//                   mapping a zero magnitude to +0 regardless of sign
// The helpers work on a MAXW-bit bus so any width up to MAXW can share them;
// callers zero-extend operands and size-cast results.
// ---------------------------------------------------------------------------
package ones_comp_pkg;

    localparam int DEFAULT_WIDTH = 15;
    localparam int MAXW          = 64;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_e;

    // Mask with the low w bits set (w = MAXW gives all ones).
    function automatic logic [MAXW-1:0] low_mask(input int w);
        logic [MAXW-1:0] one;
        one      = {{(MAXW-1){1'b0}}, 1'b1};
        low_mask = (one << w) - one;
    endfunction

    // Magnitude (bits w-2:0) of a w-bit one's-complement word.
    function automatic logic [MAXW-1:0] to_mag(input logic [MAXW-1:0] value, input int w);
        logic [MAXW-1:0] one;
        logic            sign;
        one  = {{(MAXW-1){1'b0}}, 1'b1};
        sign = |(value & (one << (w - 1)));
        if (sign) begin
            to_mag = ~value & low_mask(w - 1);
        end else begin
            to_mag = value & low_mask(w - 1);
        end
    endfunction

    // w-bit one's-complement word; a zero magnitude always becomes +0.
    function automatic logic [MAXW-1:0] apply_sign(input logic neg, input logic [MAXW-1:0] mag,
                                                   input int w);
        if (mag == {MAXW{1'b0}}) begin
            apply_sign = {MAXW{1'b0}};
        end else if (neg) begin
            apply_sign = ~mag & low_mask(w);
        end else begin
            apply_sign = mag;
        end
    endfunction

endpackage

// File: rtl/ones_comp_muldiv_seq_if.sv
// ---------------------------------------------------------------------------
// ones_comp_muldiv_seq_if
// Request/response bundle of the multiply/divide unit.
//   start, op, x, y, numer : request (driven by the master)
//   ready, done, prod, quot, remain, err : status/results (driven by the unit)
// modport master : requester side; modport slave : the unit itself.
// ---------------------------------------------------------------------------
interface ones_comp_muldiv_seq_if
    import ones_comp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic                 start;
    logic                 op;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic [2*WIDTH-1:0]   numer;
    logic                 ready;
    logic                 done;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     remain;
    logic                 err;

    modport master (
        output start, op, x, y, numer,
        input  ready, done, prod, quot, remain, err
    );

    modport slave (
        input  start, op, x, y, numer,
        output ready, done, prod, quot, remain, err
    );
endinterface

// File: rtl/ones_comp_muldiv_seq_sign_mag.sv
// ---------------------------------------------------------------------------
// ones_comp_sign_mag
// Combinational split of a WIDTH-bit one's-complement word into its sign
// and (WIDTH-1)-bit magnitude. Both +0 and -0 give magnitude 0.
//   value : one's-complement word (in)
//   sign  : value MSB (out)
//   mag   : magnitude, sign ? ~value : value without the sign bit (out)
// WIDTH must not exceed ones_comp_pkg::MAXW.
// ---------------------------------------------------------------------------
module ones_comp_sign_mag
    import ones_comp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    output logic             sign,
    output logic [WIDTH-2:0] mag
);
    assign sign = value[WIDTH-1];
    assign mag  = (WIDTH-1)'(to_mag(MAXW'(value), WIDTH));
endmodule

// File: rtl/ones_comp_muldiv_seq.sv
// ---------------------------------------------------------------------------
// ones_comp_muldiv_seq
// Iterative one's-complement multiply/divide unit (sign-magnitude datapath).
// Multiply: shift-add over WIDTH-1 multiplier bits, MSB first.
// Divide  : restoring divide, one quotient bit per cycle; divide-by-zero and
//           quotient overflow are flagged on err instead of wrapping.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : ones_comp_muldiv_seq_if.slave (start/op/x/y/numer in,
//           ready/done/prod/quot/remain/err out, all outputs registered)
// Sequence: IDLE -(start)-> CHECK -> RUN (WIDTH-1 cycles) -> FINISH -> IDLE;
// errors skip RUN. done pulses in the cycle after the FINISH edge.
// Build option: define ONES_COMP_MULDIV_DIV_EN to include the divider;
// without it quot/remain are tied to 0 and every divide returns err=1.
// WIDTH must be >= 4 and 2*WIDTH <= ones_comp_pkg::MAXW.
// ---------------------------------------------------------------------------
module ones_comp_muldiv_seq
    import ones_comp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                   clk,
    input logic                   rst_n,
    ones_comp_muldiv_seq_if.slave bus
);
    localparam int MW = WIDTH - 1;       // magnitude bits of a word
    localparam int PW = 2 * WIDTH;       // product / numerator word
    localparam int AW = 2 * WIDTH - 1;   // product / numerator magnitude
    localparam int CW = $clog2(WIDTH);   // iteration counter

    // Input sign/magnitude split
    logic          sx_s;
    logic          sy_s;
    logic [MW-1:0] xmag_s;
    logic [MW-1:0] ymag_s;

    ones_comp_sign_mag #(.WIDTH(WIDTH)) u_sm_x (.value(bus.x), .sign(sx_s), .mag(xmag_s));
    ones_comp_sign_mag #(.WIDTH(WIDTH)) u_sm_y (.value(bus.y), .sign(sy_s), .mag(ymag_s));

    // Sequencer, operand and result state
    state_e        state_q,  state_d;
    op_e           op_q,     op_d;
    logic          sx_q,     sx_d;
    logic          sy_q,     sy_d;
    logic [MW-1:0] xmag_q,   xmag_d;
    logic [MW-1:0] ymag_q,   ymag_d;
    logic [AW-1:0] acc_q,    acc_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          ready_q,  ready_d;
    logic          done_q,   done_d;
    logic [PW-1:0] prod_q,   prod_d;
    logic          err_q,    err_d;

`ifdef ONES_COMP_MULDIV_DIV_EN
    logic          sn_s;
    logic [AW-1:0] nmag_s;

    ones_comp_sign_mag #(.WIDTH(PW)) u_sm_n (.value(bus.numer), .sign(sn_s), .mag(nmag_s));

    logic             sn_q,       sn_d;
    logic [AW-1:0]    nmag_q,     nmag_d;
    logic [MW-1:0]    rem_q,      rem_d;      // partial remainder magnitude
    logic [MW-1:0]    nlo_q,      nlo_d;      // numerator bits still to shift in
    logic [MW-1:0]    quo_q,      quo_d;      // quotient magnitude
    logic             err_pend_q, err_pend_d;
    logic [WIDTH-1:0] quot_q,     quot_d;
    logic [WIDTH-1:0] remain_q,   remain_d;

    // One restoring-divide step: shift the next numerator bit into the
    // remainder and subtract the denominator when it fits.
    logic [WIDTH-1:0] trial_s;
    logic [WIDTH-1:0] diff_s;
    logic             ge_s;
    assign trial_s = {rem_q, nlo_q[MW-1]};
    assign diff_s  = trial_s - {1'b0, ymag_q};
    assign ge_s    = (trial_s >= {1'b0, ymag_q});
`endif

    // Next-state and datapath logic for all registers
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        xmag_d  = xmag_q;
        ymag_d  = ymag_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        prod_d  = prod_q;
        err_d   = err_q;
`ifdef ONES_COMP_MULDIV_DIV_EN
        sn_d       = sn_q;
        nmag_d     = nmag_q;
        rem_d      = rem_q;
        nlo_d      = nlo_q;
        quo_d      = quo_q;
        err_pend_d = err_pend_q;
        quot_d     = quot_q;
        remain_d   = remain_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = op_e'(bus.op);
                    sx_d    = sx_s;
                    sy_d    = sy_s;
                    xmag_d  = xmag_s;
                    ymag_d  = ymag_s;
`ifdef ONES_COMP_MULDIV_DIV_EN
                    sn_d    = sn_s;
                    nmag_d  = nmag_s;
`endif
                    state_d = CHECK;
                end else begin
                    state_d = IDLE;
                end
            end

            CHECK: begin
                acc_d = {AW{1'b0}};
                cnt_d = CW'(MW);
                if (op_q == OP_DIV) begin
`ifdef ONES_COMP_MULDIV_DIV_EN
                    // Upper numerator bits start as the partial remainder;
                    // they are below the denominator whenever no overflow.
                    rem_d = nmag_q[AW-2:MW];
                    nlo_d = nmag_q[MW-1:0];
                    quo_d = {MW{1'b0}};
                    // Quotient needs more than MW bits when numer >= denom << MW.
                    if ((ymag_q == {MW{1'b0}}) ||
                        (nmag_q >= {1'b0, ymag_q, {MW{1'b0}}})) begin
                        err_pend_d = 1'b1;
                        state_d    = FINISH;
                    end else begin
                        err_pend_d = 1'b0;
                        state_d    = RUN;
                    end
`else
                    state_d = FINISH;
`endif
                end else begin
                    state_d = RUN;
                end
            end

            RUN: begin
                cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                if (op_q == OP_MUL) begin
                    // MSB-first shift-add: acc = 2*acc + (ybit ? x : 0).
                    acc_d  = {acc_q[AW-2:0], 1'b0} +
                             (ymag_q[MW-1] ? {{WIDTH{1'b0}}, xmag_q} : {AW{1'b0}});
                    ymag_d = {ymag_q[MW-2:0], 1'b0};
                end else begin
`ifdef ONES_COMP_MULDIV_DIV_EN
                    rem_d = ge_s ? MW'(diff_s) : trial_s[MW-1:0];
                    nlo_d = {nlo_q[MW-2:0], 1'b0};
                    quo_d = {quo_q[MW-2:0], ge_s};
`else
                    acc_d = acc_q;
`endif
                end
                if (cnt_d == {CW{1'b0}}) begin
                    state_d = FINISH;
                end else begin
                    state_d = RUN;
                end
            end

            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (op_q == OP_MUL) begin
                    prod_d = PW'(apply_sign(sx_q ^ sy_q, MAXW'(acc_q), PW));
                    err_d  = 1'b0;
                end else begin
`ifdef ONES_COMP_MULDIV_DIV_EN
                    if (err_pend_q) begin
                        quot_d   = {WIDTH{1'b0}};
                        remain_d = {WIDTH{1'b0}};
                        err_d    = 1'b1;
                    end else begin
                        quot_d   = WIDTH'(apply_sign(sn_q ^ sy_q, MAXW'(quo_q), WIDTH));
                        remain_d = WIDTH'(apply_sign(sn_q, MAXW'(rem_q), WIDTH));
                        err_d    = 1'b0;
                    end
`else
                    err_d = 1'b1;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            xmag_q  <= {MW{1'b0}};
            ymag_q  <= {MW{1'b0}};
            acc_q   <= {AW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            prod_q  <= {PW{1'b0}};
            err_q   <= 1'b0;
`ifdef ONES_COMP_MULDIV_DIV_EN
            sn_q       <= 1'b0;
            nmag_q     <= {AW{1'b0}};
            rem_q      <= {MW{1'b0}};
            nlo_q      <= {MW{1'b0}};
            quo_q      <= {MW{1'b0}};
            err_pend_q <= 1'b0;
            quot_q     <= {WIDTH{1'b0}};
            remain_q   <= {WIDTH{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            xmag_q  <= xmag_d;
            ymag_q  <= ymag_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
`ifdef ONES_COMP_MULDIV_DIV_EN
            sn_q       <= sn_d;
            nmag_q     <= nmag_d;
            rem_q      <= rem_d;
            nlo_q      <= nlo_d;
            quo_q      <= quo_d;
            err_pend_q <= err_pend_d;
            quot_q     <= quot_d;
            remain_q   <= remain_d;
`endif
        end
    end

    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.prod   = prod_q;
    assign bus.err    = err_q;
`ifdef ONES_COMP_MULDIV_DIV_EN
    assign bus.quot   = quot_q;
    assign bus.remain = remain_q;
`else
    assign bus.quot   = {WIDTH{1'b0}};
    assign bus.remain = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_ones_comp_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_ones_comp_muldiv_seq
// Directed bench for ones_comp_muldiv_seq at WIDTH=15. A vector table covers
// multiply/divide results, signs, +0 handling, error paths and latency;
// hand-written sequences cover start during RUN/FINISH and reset mid-RUN.
// Divide expectations follow ONES_COMP_MULDIV_DIV_EN.
// ---------------------------------------------------------------------------
module tb_ones_comp_muldiv_seq;
    localparam int W = 15;

    logic clk = 1'b0;
    logic rst_n;

    ones_comp_muldiv_seq_if #(.WIDTH(W)) bus ();

    ones_comp_muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           op;
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [2*W-1:0] numer;
        logic [2*W-1:0] prod;
        logic [W-1:0]   quot;
        logic [W-1:0]   rem;
        logic           err;
        int             lat;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, " ready_before_start"}, 64'(bus.ready), 64'd1);
    endtask

    // Issue one operation, measure start-to-done edges, check results.
    task automatic run_vec(input vec_t v, input string name);
        int lat = 0;
        int ready_hi = 0;
        wait_ready(name);
        bus.op    = v.op;
        bus.x     = v.x;
        bus.y     = v.y;
        bus.numer = v.numer;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.x     = '1;
        bus.y     = '1;
        bus.numer = '1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            if (bus.ready === 1'b1) ready_hi++;
        end
        chk({name, " latency"},  64'(lat),        64'(v.lat));
        chk({name, " ready_low"}, 64'(ready_hi),  64'd0);
        chk({name, " prod"},     64'(bus.prod),   64'(v.prod));
        chk({name, " quot"},     64'(bus.quot),   64'(v.quot));
        chk({name, " remain"},   64'(bus.remain), 64'(v.rem));
        chk({name, " err"},      64'(bus.err),    64'(v.err));
        @(posedge clk);
        #1;
        chk({name, " done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ndone;
        vec_t v;

        //             op   x         y         numer          prod           quot      rem       err   lat
        vecs[0]  = '{1'b0, 15'd3,    15'd5,    30'd0,         30'd15,        15'd0,    15'd0,    1'b0, 16};
        vecs[1]  = '{1'b0, 15'h7FFC, 15'd5,    30'd0,         30'h3FFFFFF0,  15'd0,    15'd0,    1'b0, 16};
        vecs[2]  = '{1'b0, 15'h7FFF, 15'd7,    30'd0,         30'd0,         15'd0,    15'd0,    1'b0, 16};
        vecs[3]  = '{1'b0, 15'h3FFF, 15'h3FFF, 30'd0,         30'h0FFF8001,  15'd0,    15'd0,    1'b0, 16};
        vecs[4]  = '{1'b0, 15'h4000, 15'h3FFF, 30'd0,         30'h30007FFE,  15'd0,    15'd0,    1'b0, 16};
        vecs[5]  = '{1'b0, 15'h7FFD, 15'h7FFC, 30'd0,         30'd6,         15'd0,    15'd0,    1'b0, 16};
        vecs[6]  = '{1'b1, 15'd0,    15'd7,    30'd100,       30'd6,         15'd14,   15'd2,    1'b0, 16};
        vecs[7]  = '{1'b1, 15'd0,    15'd7,    30'h3FFFFF9B,  30'd6,         15'h7FF1, 15'h7FFD, 1'b0, 16};
        vecs[8]  = '{1'b1, 15'd0,    15'h7FF8, 30'd100,       30'd6,         15'h7FF1, 15'd2,    1'b0, 16};
        vecs[9]  = '{1'b1, 15'd0,    15'h7FFF, 30'd100,       30'd6,         15'd0,    15'd0,    1'b1, 2};
        vecs[10] = '{1'b1, 15'd0,    15'd1,    30'h10000000,  30'd6,         15'd0,    15'd0,    1'b1, 2};
        vecs[11] = '{1'b1, 15'd0,    15'd1,    30'd16383,     30'd6,         15'h3FFF, 15'd0,    1'b0, 16};
        vecs[12] = '{1'b1, 15'd0,    15'd1,    30'd16384,     30'd6,         15'd0,    15'd0,    1'b1, 2};
        vecs[13] = '{1'b1, 15'd0,    15'd7,    30'h3FFFFFF9,  30'd6,         15'd0,    15'h7FF9, 1'b0, 16};
        vecs[14] = '{1'b0, 15'd1,    15'd1,    30'd0,         30'd1,         15'd0,    15'h7FF9, 1'b0, 16};
`ifndef ONES_COMP_MULDIV_DIV_EN
        for (int i = 6; i <= 13; i++) begin
            vecs[i].quot = '0;
            vecs[i].rem  = '0;
            vecs[i].err  = 1'b1;
            vecs[i].lat  = 2;
        end
        vecs[14].rem = '0;
`endif

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        bus.numer = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready",  64'(bus.ready),  64'd1);
        chk("reset done",   64'(bus.done),   64'd0);
        chk("reset prod",   64'(bus.prod),   64'd0);
        chk("reset quot",   64'(bus.quot),   64'd0);
        chk("reset remain", 64'(bus.remain), 64'd0);
        chk("reset err",    64'(bus.err),    64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // start pulsed during RUN and in the FINISH cycle must be ignored
        wait_ready("pulse");
        bus.op = 1'b0; bus.x = 15'd3; bus.y = 15'd5; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 40; k++) begin
            bus.start = (k == 5 || k == 15) ? 1'b1 : 1'b0;
            bus.x = 15'd9;
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                ndone++;
                chk("pulse done_edge", 64'(k), 64'd16);
            end
        end
        bus.start = 1'b0;
        chk("pulse done_count", 64'(ndone), 64'd1);
        chk("pulse prod", 64'(bus.prod), 64'd15);

        // reset in the middle of RUN aborts without done
        wait_ready("rstmid");
        bus.op = 1'b0; bus.x = 15'h3FFF; bus.y = 15'h3FFF; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rstmid ready",  64'(bus.ready),  64'd1);
        chk("rstmid done",   64'(bus.done),   64'd0);
        chk("rstmid prod",   64'(bus.prod),   64'd0);
        chk("rstmid quot",   64'(bus.quot),   64'd0);
        chk("rstmid remain", 64'(bus.remain), 64'd0);
        chk("rstmid err",    64'(bus.err),    64'd0);
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) ndone++;
        end
        chk("rstmid no_done", 64'(ndone), 64'd0);

        v = '{1'b0, 15'd3, 15'd5, 30'd0, 30'd15, 15'd0, 15'd0, 1'b0, 16};
        run_vec(v, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
